// File: rtl/tc_timer_core_if.sv
// rtl/tc_timer_core_if.sv - control/status bundle between the timer core and its wrapper
interface tc_timer_core_if #(
  parameter int WIDTH = 8,
  parameter int PW    = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] cmp;
  logic             ext_in;
  logic             start;
  logic             clr;
  logic [WIDTH-1:0] count;
  logic             match;
  logic             ovf;
  logic             wave;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, presc, cmp, ext_in, start, clr,
    input  count, match, ovf, wave, busy, done
  );

  modport slave (
    input  en, mode, presc, cmp, ext_in, start, clr,
    output count, match, ovf, wave, busy, done
  );
endinterface

// File: rtl/tc_timer_core.sv
// rtl/tc_timer_core.sv - prescaled up-counter with compare-reload, event input and one-shot FSM
module tc_timer_core #(
  parameter int WIDTH = 8,
  parameter int PW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  tc_timer_core_if.slave  tmr
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [1:0] MODE_STOP  = 2'b00;
  localparam logic [1:0] MODE_EVENT = 2'b10;
  localparam logic [1:0] MODE_ONE   = 2'b11;

  state_e           state_q;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             match_q, ovf_q, wave_q, busy_q, done_q;
  logic             s1_q, s2_q, s3_q, ev_q;
  logic             tick, inc, at_cmp, at_max;

  // Synchronizer and edge detector keep sampling through freeze and clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
      ev_q <= 1'b0;
    end else begin
      s1_q <= tmr.ext_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
      ev_q <= s2_q & ~s3_q;
    end
  end

  always_comb begin
    tick    = (pcnt_q >= tmr.presc);
    inc     = (tmr.mode == MODE_EVENT) ? ev_q : tick;
    at_cmp  = (count_q == tmr.cmp);
    at_max  = (count_q == {WIDTH{1'b1}});
    count_d = (at_cmp || at_max) ? '0 : count_q + 1'b1;
    pcnt_d  = pcnt_q;
    if (tmr.mode != MODE_EVENT) pcnt_d = tick ? '0 : pcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      count_q <= '0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
      wave_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (tmr.clr || tmr.mode == MODE_STOP) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      count_q <= '0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (tmr.en) begin
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (tmr.start) begin
            state_q <= RUN;
            pcnt_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          pcnt_q <= pcnt_d;
          if (inc) begin
            count_q <= count_d;
            match_q <= at_cmp;
            ovf_q   <= at_max;
            if (at_cmp) begin
              wave_q <= ~wave_q;
              if (tmr.mode == MODE_ONE) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tmr.count = count_q;
  assign tmr.match = match_q;
  assign tmr.ovf   = ovf_q;
  assign tmr.wave  = wave_q;
  assign tmr.busy  = busy_q;
  assign tmr.done  = done_q;
endmodule

// File: doc/tc_timer_core.md
# tc_timer_core

Timer/counter datapath and control core instantiated by the `tt06_um_timer_counter_UGM` top-level wrapper, which maps its ports onto `ui_in`/`uio_in`/`uo_out`. It contains the prescaler, the external-event synchronizer and edge detector, and the up-counter with compare-reload. It also runs the run/one-shot state machine. It produces the count value and the match/overflow/waveform outputs that the wrapper drives onto the pads.

## Interface
- `WIDTH`, 8: counter and compare width.
- `PW`, 8: prescaler reload width.

- `clk` in 1: the single clock; every flop is on its rising edge.
- `rst` in 1: reset, synchronous, active-high. The wrapper drives it as `~rst_n`.
- `en` in 1: global enable. When 0, the prescaler, counter and FSM all freeze.
- `mode` in 2: 00 stop, 01 free-run timer, 10 event counter, 11 one-shot timer.
- `presc` in PW: prescale value. A timer tick occurs every `presc+1` enabled cycles.
- `cmp` in WIDTH: compare/reload value.
- `ext_in` in 1: asynchronous external event input. Rising edges are counted.
- `start` in 1: single-cycle start strobe.
- `clr` in 1: synchronous clear strobe.
- `count` out WIDTH: current count.
- `match` out 1: one-cycle pulse when the counter wraps at `cmp`.
- `ovf` out 1: one-cycle pulse when the counter wraps from 2^WIDTH-1.
- `wave` out 1: toggles on every `match`.
- `busy` out 1: high while in RUN.
- `done` out 1: high while in DONE.

## Operation
- **Reset.** All outputs go to 0. The prescaler counter and the synchronizer flops go to 0. The FSM goes to IDLE.
- **FSM states.** IDLE, RUN, DONE.
  - IDLE → RUN: on `start` with `mode`≠00.
  - RUN → DONE: on `match` in mode 11.
  - DONE → RUN: on `start`.
  - Any state → IDLE: on `clr`, or when `mode`=00.
- **Counter outside RUN.** In IDLE the count holds 0. In DONE the count holds 0.
- **Priority.** `rst` > `clr` > `mode`=00 > `en`=0 (freeze) > `start` > increment.
- **Start.** `start` while in RUN is ignored. `start` entering RUN, from IDLE or DONE, clears the prescaler counter to 0.
- **Prescaler.** The prescaler counter advances only in RUN with `en`=1. `tick` asserts when `pcnt >= presc`, and `pcnt` then returns to 0. The `>=` compare means that lowering `presc` below `pcnt` produces a tick on the next cycle. `presc`=0 gives a tick every cycle.
- **Event path.** `ext_in` passes through a 2-flop synchronizer, then a registered edge detector (`s2 & ~s3`). This yields a one-cycle `ev` pulse.
- **Increment source.** Modes 01 and 11 increment on `tick`. Mode 10 increments on `ev`; the prescaler is ignored in mode 10.
- **Increment rule**, applied at each increment:
  - If `count == cmp`, then `count` becomes 0 and `match` is set.
  - Else if `count == 2^WIDTH-1`, then `count` becomes 0 and `ovf` is set.
  - Else `count` becomes `count+1`.
  - If `cmp == 2^WIDTH-1`, the wrap sets both `match` and `ovf` in the same cycle.
  - If `cmp` is lowered below the current `count`, the counter runs to the maximum, overflows, and matches on the following lap.
  - `cmp`=0 gives a match on every increment; `count` stays at 0 and `wave` toggles on each increment.
- **Register updates.** `match`/`ovf` are registered. They are high for exactly the one cycle in which `count` shows the wrapped 0. `wave` flips on the same edge.
- **Clear.** `clr` zeroes `count` and `pcnt`, and sends the FSM to IDLE. It does not reset `wave` or the synchronizer.

## Timing
- **First timer tick.** `start` is sampled at edge N, so RUN is active from N. The first tick is at edge N+presc+1, where `count` becomes 1. After that the period is `presc+1` cycles per increment.
- **Full lap.** A free-run lap lasts `(cmp+1)·(presc+1)` cycles.
- **Event latency.** `ext_in` rises before edge E with setup met. The flop `s1` captures it at E, `s2` at E+1, and `ev` is registered at E+2. `count` updates at E+3.
  - Minimum countable event width: 1 cycle high and 1 cycle low.
- **One-shot end.** The match in mode 11 sets `done`=1, `busy`=0 and `count`=0 on the same edge.
- **Freeze.** `en`=0 holds every register, except that the synchronizer keeps sampling. Events whose `ev` pulse falls while `en`=0 are dropped.
- **Reset mid-run.** `rst` takes effect at the next edge. No pulse is emitted on that edge.

## Test plan
- **Reset.** Assert `rst` for 2 cycles with random inputs → `count`=0, and `match`, `ovf`, `wave`, `busy`, `done` all 0. The FSM stays IDLE until `start`.
- **Free-run timer.** `mode`=01, `presc`=3, `cmp`=4, `start` at edge N → `count` becomes 1,2,3,4 at N+4, N+8, N+12, N+16. At N+20 `count` is 0, `match`=1 for one cycle, and `wave`=1. The next match is at N+40 with `wave`=0.
- **Event counter.** `mode`=10, `cmp`=255. Apply 5 `ext_in` pulses, each 2 cycles high and 3 low → `count`=5. Each increment lands exactly 3 edges after its rising edge. The level of `presc` has no effect.
- **One-shot.** `mode`=11, `presc`=0, `cmp`=2, `start` → `count` goes 1, 2, then 0 with `match`. `done`=1 and `busy`=0, and `count` holds 0 for 10 cycles. A second `start` repeats the sequence identically.
- **Overflow.**
  - `mode`=01, `presc`=0, `cmp`=255 → after 256 increments, `match` and `ovf` pulse together and `count` is 0.
  - Rerun with `cmp`=200. When `count`=20, drop `cmp` to 10 → the counter runs to 255, `ovf` pulses alone, and on the next lap `match` pulses at the 10→0 wrap.
- **Control priority.**
  - `clr` and `start` in the same cycle → IDLE, `count`=0.
  - `en`=0 for 7 cycles mid-run → `count` and `pcnt` frozen; the run resumes with the tick phase preserved.
  - `mode`=00 mid-run → IDLE on the next edge.
